// File: rtl/rotl_pkg.sv
// Shared constants and rotate helpers for the pipelined left-rotator.
// Helpers work on a wide word and an explicit active width so any power-of-two WIDTH can use them.
package rotl_pkg;

  localparam int ROTL_WIDTH = 8;
  localparam int ROTL_MAX_W = 64;

  typedef logic [ROTL_MAX_W-1:0] rotl_word_t;

  // Rotate the low w bits of data left by a fixed amount sh; bits above w come back as zero.
  function automatic rotl_word_t rotl_by(input rotl_word_t data, input int unsigned sh,
                                         input int unsigned w);
    rotl_word_t res;
    res = '0;
    for (int unsigned i = 0; i < ROTL_MAX_W; i++) begin
      if (i < w) begin
        res[(i + sh) % w] = data[i];
      end
    end
    return res;
  endfunction

  // Reference full rotate written as plain shift-or arithmetic.
  function automatic rotl_word_t rotl_full(input rotl_word_t data, input int unsigned n,
                                           input int unsigned w);
    rotl_word_t mask;
    rotl_word_t d;
    mask = (w >= ROTL_MAX_W) ? '1 : ((rotl_word_t'(1) << w) - rotl_word_t'(1));
    d = data & mask;
    if (n == 0) begin
      return d;
    end
    return ((d << n) | (d >> (w - n))) & mask;
  endfunction

endpackage

// File: rtl/rotl_stage.sv
// One register stage of the rotator: conditional rotate-left by 2^SHIFT_BIT
// plus the valid/ready slot logic that lets bubbles collapse under back-pressure.
module rotl_stage
  import rotl_pkg::*;
#(
  parameter int WIDTH     = ROTL_WIDTH,
  parameter int AMT_W     = $clog2(WIDTH),
  parameter int SHIFT_BIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic [AMT_W-1:0] prev_amt,
  output logic             prev_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [AMT_W-1:0] amt,
  input  logic             next_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [WIDTH-1:0] rot_data;

  always_comb begin
    prev_ready = !valid_q || next_ready;
    rot_data   = prev_amt[SHIFT_BIT]
               ? WIDTH'(rotl_by(ROTL_MAX_W'(prev_data), 32'(1) << SHIFT_BIT, WIDTH))
               : prev_data;
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    if (prev_ready) begin
      valid_d = prev_valid;
      // A bubble advances the valid bit only; the payload keeps its last value.
      if (prev_valid) begin
        data_d = rot_data;
        amt_d  = prev_amt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign amt   = amt_q;

endmodule

// File: rtl/barrel_rotl_pipe.sv
// Pipelined logarithmic left-rotator: AMT_W rotl_stage instances, LSB amount bit first,
// chained through a per-stage ready path so the pipe holds AMT_W words.
module barrel_rotl_pipe
  import rotl_pkg::*;
#(
  parameter  int WIDTH = ROTL_WIDTH,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             stage_valid [AMT_W];
  logic [WIDTH-1:0] stage_data  [AMT_W];
  logic [AMT_W-1:0] stage_amt   [AMT_W];
  logic             stage_ready [AMT_W+1];
  logic [AMT_W-1:0] tail_amt_unused;

  assign stage_ready[AMT_W] = out_ready;
  assign in_ready           = stage_ready[0];
  assign out_valid          = stage_valid[AMT_W-1];
  assign out_data           = stage_data[AMT_W-1];
  // The last stage's carried amount has no consumer downstream.
  assign tail_amt_unused    = stage_amt[AMT_W-1];

  generate
    for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;
      logic [AMT_W-1:0] src_amt;

      if (gi == 0) begin : g_head
        assign src_valid = in_valid;
        assign src_data  = in_data;
        assign src_amt   = in_amt;
      end else begin : g_body
        assign src_valid = stage_valid[gi-1];
        assign src_data  = stage_data[gi-1];
        assign src_amt   = stage_amt[gi-1];
      end

      rotl_stage #(
        .WIDTH    (WIDTH),
        .AMT_W    (AMT_W),
        .SHIFT_BIT(gi)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .prev_valid(src_valid),
        .prev_data (src_data),
        .prev_amt  (src_amt),
        .prev_ready(stage_ready[gi]),
        .valid     (stage_valid[gi]),
        .data      (stage_data[gi]),
        .amt       (stage_amt[gi]),
        .next_ready(stage_ready[gi+1])
      );
    end
  endgenerate

endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// Self-checking bench for barrel_rotl_pipe: table vectors, inverse sweep, throughput,
// back-pressure, mid-flight reset and randomized traffic against a shift-or reference.
module tb_barrel_rotl_pipe;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;

  barrel_rotl_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         acc;
  bit         emit;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [7:0] e;
  } vec_t;

  function automatic logic [7:0] ref_rotl(input logic [7:0] d, input int n);
    int x;
    x = int'(d);
    return 8'(((x << n) | (x >> (8 - n))) & 255);
  endfunction

  function automatic logic [7:0] ref_rotr(input logic [7:0] d, input int n);
    int x;
    x = int'(d);
    return 8'(((x >> n) | (x << (8 - n))) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle at the falling edge, then sample the handshakes that the next rising edge commits.
  task automatic do_cycle(input logic v, input logic [7:0] d, input logic [2:0] a,
                          input logic [7:0] e, input logic o_r);
    logic [7:0] x;
    @(negedge clk);
    cyc++;
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    out_ready = o_r;
    #1;
    if (stall_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(stall_data));
    end
    acc  = in_valid && in_ready;
    emit = out_valid && out_ready;
    if (emit) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        x = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(x));
      end
    end
    if (acc) exp_q.push_back(e);
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) do_cycle(1'b0, 8'h00, 3'd0, 8'h00, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[10];
    logic [7:0] bp_d[5];
    logic [2:0] bp_a[5];
    int         k;
    int         first_acc;
    int         first_emit;
    int         last_emit;
    int         n_emit;
    int         n_acc;
    int         stale;
    logic [7:0] d;
    logic [2:0] a;

    vecs[0] = '{8'hB4, 3'd3, 8'hA5};
    vecs[1] = '{8'h5A, 3'd0, 8'h5A};
    vecs[2] = '{8'h01, 3'd7, 8'h80};
    vecs[3] = '{8'h80, 3'd1, 8'h01};
    vecs[4] = '{8'hFF, 3'd5, 8'hFF};
    vecs[5] = '{8'hFF, 3'd7, 8'hFF};
    vecs[6] = '{8'h3C, 3'd2, 8'hF0};
    vecs[7] = '{8'h81, 3'd4, 8'h18};
    vecs[8] = '{8'h12, 3'd4, 8'h21};
    vecs[9] = '{8'h96, 3'd6, 8'hA5};

    // Reset state, during and right after reset
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors, one word at a time
    foreach (vecs[i]) begin
      do_cycle(1'b1, vecs[i].d, vecs[i].a, vecs[i].e, 1'b1);
      check("vec_accepted", 32'(acc), 32'd1);
      drain();
    end

    // Throughput and latency: 16 back-to-back words
    first_acc = -1; first_emit = -1; last_emit = -1; n_emit = 0; n_acc = 0;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      a = 3'($urandom);
      do_cycle(i < 16, d, a, ref_rotl(d, int'(a)), 1'b1);
      if (acc) begin
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (emit) begin
        n_emit++;
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
      end
    end
    check("tp_accepted", 32'(n_acc), 32'd16);
    check("tp_emitted", 32'(n_emit), 32'd16);
    check("tp_latency", 32'(first_emit - first_acc), 32'd3);
    check("tp_contiguous", 32'(last_emit - first_emit), 32'd15);
    drain();

    // Back-pressure: 5 words offered into a stalled pipe
    for (int i = 0; i < 5; i++) begin
      bp_d[i] = 8'($urandom);
      bp_a[i] = 3'($urandom);
    end
    k = 0;
    for (int c = 0; c < 5; c++) begin
      do_cycle(1'b1, bp_d[k], bp_a[k], ref_rotl(bp_d[k], int'(bp_a[k])), 1'b0);
      if (acc) k++;
    end
    check("bp_accepted", 32'(k), 32'd3);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    do_cycle(1'b1, bp_d[k], bp_a[k], ref_rotl(bp_d[k], int'(bp_a[k])), 1'b1);
    check("bp_full_accept", 32'(acc), 32'd1);
    check("bp_full_emit", 32'(emit), 32'd1);
    if (acc) k++;
    for (int c = 0; c < 20 && k < 5; c++) begin
      do_cycle(1'b1, bp_d[k], bp_a[k], ref_rotl(bp_d[k], int'(bp_a[k])), 1'b1);
      if (acc) k++;
    end
    check("bp_all_accepted", 32'(k), 32'd5);
    drain();

    // Inverse sweep: rotl(rotr(x,k),k) == x
    for (int dv = 0; dv < 256; dv++) begin
      for (int av = 0; av < 8; av++) begin
        do_cycle(1'b1, ref_rotr(8'(dv), av), 3'(av), 8'(dv), 1'b1);
      end
    end
    drain();

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      d = 8'($urandom);
      a = 3'($urandom);
      do_cycle(($urandom % 4) != 0, d, a, ref_rotl(d, int'(a)), ($urandom % 3) != 0);
    end
    drain();

    // Reset with three words in flight
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 8'hC3 + 8'(i), 3'(i + 1), 8'h00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b0, 8'h00, 3'd0, 8'h00, 1'b1);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    do_cycle(1'b1, 8'h3C, 3'd2, 8'hF0, 1'b1);
    check("midrst_new_accept", 32'(acc), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
